// File: rtl/color_gain_stream_pkg.sv
// Shared constants for the colour-gain stream: default widths, image size,
// tag bit positions and the unity-gain helper.
package color_gain_stream_pkg;

   localparam int unsigned CGS_DATA_W    = 8;
   localparam int unsigned CGS_GAIN_W    = 10;
   localparam int unsigned CGS_GAIN_FRAC = 8;
   localparam int unsigned CGS_IMG_W     = 20;
   localparam int unsigned CGS_IMG_H     = 15;

   // Tag vector layout {sof, eol, eof}
   localparam int unsigned TAG_SOF = 2;
   localparam int unsigned TAG_EOL = 1;
   localparam int unsigned TAG_EOF = 0;

   typedef logic [2:0] tag_t;

   // Unity gain for a fixed-point gain with 'frac' fractional bits
   function automatic int unsigned unity_gain(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

endpackage

// File: rtl/color_gain_stream_channel.sv
// One colour channel: S1 captures pixel/gain/bypass, S2 multiplies and rounds,
// S3 saturates into the output register. Each stage loads only on its enable.
module color_gain_channel
   import color_gain_stream_pkg::*;
#(
   parameter int DATA_W    = CGS_DATA_W,
   parameter int GAIN_W    = CGS_GAIN_W,
   parameter int GAIN_FRAC = CGS_GAIN_FRAC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ld1_i,
   input  logic              ld2_i,
   input  logic              ld3_i,
   input  logic [DATA_W-1:0] pix_i,
   input  logic [GAIN_W-1:0] gain_i,
   input  logic              byp_i,
   output logic [DATA_W-1:0] pix_o
);

   // One spare bit so the rounding constant can never overflow the product
   localparam int PW = DATA_W + GAIN_W + 1;
   localparam logic [PW-1:0] HALF = PW'(1) << (GAIN_FRAC - 1);
   localparam logic [PW-1:0] MAXV = PW'({DATA_W{1'b1}});

   logic [DATA_W-1:0] pix1_q;
   logic [GAIN_W-1:0] gain1_q;
   logic              byp1_q;
   logic [PW-1:0]     q2_q, q2_d;
   logic [DATA_W-1:0] pix3_q, pix3_d;

   // S1: capture the accepted pixel with the gain/bypass in force for its frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix1_q  <= '0;
         gain1_q <= '0;
         byp1_q  <= 1'b0;
      end else if (ld1_i) begin
         pix1_q  <= pix_i;
         gain1_q <= gain_i;
         byp1_q  <= byp_i;
      end
   end

   // S2 next value: rounded product, or the raw pixel when bypassed
   always_comb begin
      q2_d = PW'(pix1_q);
      if (!byp1_q) begin
         q2_d = (PW'(pix1_q) * PW'(gain1_q) + HALF) >> GAIN_FRAC;
      end
   end

   // S2 register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q2_q <= '0;
      end else if (ld2_i) begin
         q2_q <= q2_d;
      end
   end

   // S3 next value: clamp to the channel maximum
   always_comb begin
      pix3_d = q2_q[DATA_W-1:0];
      if (q2_q > MAXV) begin
         pix3_d = '1;
      end
   end

   // S3 output register; holds its value while no new pixel arrives
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix3_q <= '0;
      end else if (ld3_i) begin
         pix3_q <= pix3_d;
      end
   end

   assign pix_o = pix3_q;

endmodule

// File: rtl/color_gain_stream.sv
// RGB white-balance gain stream: valid/ready handshake with a single global
// pipeline enable, raster counters, per-frame gain/bypass shadowing and
// sof/eol/eof tags carried alongside the three channel pipelines.
module color_gain_stream
   import color_gain_stream_pkg::*;
#(
   parameter int DATA_W    = CGS_DATA_W,
   parameter int GAIN_W    = CGS_GAIN_W,
   parameter int GAIN_FRAC = CGS_GAIN_FRAC,
   parameter int IMG_W     = CGS_IMG_W,
   parameter int IMG_H     = CGS_IMG_H
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] R,
   input  logic [DATA_W-1:0] G,
   input  logic [DATA_W-1:0] B,
   input  logic [GAIN_W-1:0] gain_R,
   input  logic [GAIN_W-1:0] gain_G,
   input  logic [GAIN_W-1:0] gain_B,
   input  logic              bypass,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] R_out,
   output logic [DATA_W-1:0] G_out,
   output logic [DATA_W-1:0] B_out,
   output logic              sof,
   output logic              eol,
   output logic              eof
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

   logic          en, acc;
   logic          v1_q, v2_q, v3_q;
   tag_t          tag1_q, tag2_q, tag3_q, tag_in;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          first_px, last_col, last_row;

   logic [GAIN_W-1:0] gr_act_q, gg_act_q, gb_act_q;
   logic              byp_act_q;
   logic [GAIN_W-1:0] gr_sel, gg_sel, gb_sel;
   logic              byp_sel;

   assign en       = ~v3_q | out_ready;
   assign in_ready = en;
   assign acc      = in_valid & en;

   assign first_px = (col_q == '0) && (row_q == '0);
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == RW'(IMG_H - 1));

   always_comb begin
      tag_in          = '0;
      tag_in[TAG_SOF] = first_px;
      tag_in[TAG_EOL] = last_col;
      tag_in[TAG_EOF] = last_col && last_row;
   end

   // The first pixel of a frame uses the freshly presented gains, which also
   // become the active set for the rest of that frame.
   always_comb begin
      gr_sel  = first_px ? gain_R : gr_act_q;
      gg_sel  = first_px ? gain_G : gg_act_q;
      gb_sel  = first_px ? gain_B : gb_act_q;
      byp_sel = first_px ? bypass : byp_act_q;
   end

   // Active gain/bypass shadow registers, reloaded only at frame start
   always_ff @(posedge Clock) begin
      if (Reset) begin
         gr_act_q  <= UNITY;
         gg_act_q  <= UNITY;
         gb_act_q  <= UNITY;
         byp_act_q <= 1'b0;
      end else if (acc && first_px) begin
         gr_act_q  <= gain_R;
         gg_act_q  <= gain_G;
         gb_act_q  <= gain_B;
         byp_act_q <= bypass;
      end
   end

   // Raster position next-state: advance on accepted pixels only
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (acc) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Raster position registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Stage valids advance together under the global enable
   always_ff @(posedge Clock) begin
      if (Reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (en) begin
         v1_q <= acc;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // Tags follow their pixel; the output tag register only loads real pixels
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tag1_q <= '0;
         tag2_q <= '0;
         tag3_q <= '0;
      end else begin
         if (acc)         tag1_q <= tag_in;
         if (en && v1_q)  tag2_q <= tag1_q;
         if (en && v2_q)  tag3_q <= tag2_q;
      end
   end

   color_gain_channel #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_ch_r (
      .clk_i(Clock), .rst_i(Reset), .ld1_i(acc), .ld2_i(en && v1_q), .ld3_i(en && v2_q),
      .pix_i(R), .gain_i(gr_sel), .byp_i(byp_sel), .pix_o(R_out)
   );

   color_gain_channel #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_ch_g (
      .clk_i(Clock), .rst_i(Reset), .ld1_i(acc), .ld2_i(en && v1_q), .ld3_i(en && v2_q),
      .pix_i(G), .gain_i(gg_sel), .byp_i(byp_sel), .pix_o(G_out)
   );

   color_gain_channel #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_ch_b (
      .clk_i(Clock), .rst_i(Reset), .ld1_i(acc), .ld2_i(en && v1_q), .ld3_i(en && v2_q),
      .pix_i(B), .gain_i(gb_sel), .byp_i(byp_sel), .pix_o(B_out)
   );

   assign out_valid = v3_q;
   assign sof       = tag3_q[TAG_SOF];
   assign eol       = tag3_q[TAG_EOL];
   assign eof       = tag3_q[TAG_EOF];

endmodule

// File: tb/tb_color_gain_stream.sv
// Scoreboard bench for color_gain_stream: a driver feeds random pixels and
// pushes expected results from a frame-level reference model; a monitor pops
// and compares whenever an output transfer happens.
module tb_color_gain_stream;

   localparam int DW = 8, GW = 10, GF = 8, IW = 20, IH = 15;
   localparam int NPIX = IW * IH;
   localparam int MAXV = (1 << DW) - 1;
   localparam int UNITY = 1 << GF;

   logic          Clock = 1'b0;
   logic          Reset, in_valid, in_ready, bypass, out_valid, out_ready;
   logic [DW-1:0] R, G, B, R_out, G_out, B_out;
   logic [GW-1:0] gain_R, gain_G, gain_B;
   logic          sof, eol, eof;

   color_gain_stream #(.DATA_W(DW), .GAIN_W(GW), .GAIN_FRAC(GF), .IMG_W(IW), .IMG_H(IH)) dut (
      .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .R(R), .G(G), .B(B), .gain_R(gain_R), .gain_G(gain_G), .gain_B(gain_B),
      .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
      .R_out(R_out), .G_out(G_out), .B_out(B_out), .sof(sof), .eol(eol), .eof(eof)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int r, g, b;
      bit s, l, f;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   lat_chk = 0;

   // Reference model state: position in frame and the gain set of the frame
   int   m_idx = 0, m_gr = UNITY, m_gg = UNITY, m_gb = UNITY;
   bit   m_byp = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic int apply_gain(input int pix, input int gain, input bit byp);
      int q;
      if (byp) return pix;
      q = (pix * gain + UNITY / 2) / UNITY;
      return (q > MAXV) ? MAXV : q;
   endfunction

   // Expected output for the pixel currently on the inputs, advancing the model
   task automatic model_accept(input int c, output exp_t e);
      if (m_idx == 0) begin
         m_gr  = int'(gain_R);
         m_gg  = int'(gain_G);
         m_gb  = int'(gain_B);
         m_byp = bypass;
      end
      e.r   = apply_gain(int'(R), m_gr, m_byp);
      e.g   = apply_gain(int'(G), m_gg, m_byp);
      e.b   = apply_gain(int'(B), m_gb, m_byp);
      e.s   = (m_idx == 0);
      e.l   = ((m_idx % IW) == IW - 1);
      e.f   = (m_idx == NPIX - 1);
      e.cyc = c;
      m_idx = (m_idx + 1) % NPIX;
   endtask

   // Present one pixel until accepted; bp adds input bubbles and random out_ready
   task automatic send(input int r, input int g, input int b, input bit bp);
      int   tries = 0;
      bit   acc = 0;
      exp_t e;
      while (!acc) begin
         in_valid  = !(bp && $urandom_range(0, 3) == 0);
         R = DW'(r); G = DW'(g); B = DW'(b);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge Clock);
         acc = in_valid && in_ready;
         if (acc) model_accept(cyc, e);
         @(posedge Clock);
         if (acc) sb.push_back(e);
         #1;
         tries++;
         if (!acc && tries > 200) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() > 0 && n < 20) begin
         @(posedge Clock); #1;
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   // One-cycle reset with a pixel offered in the same cycle (must be dropped)
   task automatic do_reset();
      Reset     = 1'b1;
      in_valid  = 1'b1;
      R = DW'($urandom); G = DW'($urandom); B = DW'($urandom);
      out_ready = 1'b0;
      @(posedge Clock); #1;
      Reset    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      m_idx = 0; m_gr = UNITY; m_gg = UNITY; m_gb = UNITY; m_byp = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_R_out", int'(R_out), 0);
      chk("rst_G_out", int'(G_out), 0);
      chk("rst_B_out", int'(B_out), 0);
      chk("rst_tags", int'({sof, eol, eof}), 0);
      chk("rst_in_ready", int'(in_ready), 1);
   endtask

   task automatic set_gains(input int gr, input int gg, input int gb, input bit byp);
      gain_R = GW'(gr); gain_G = GW'(gg); gain_B = GW'(gb); bypass = byp;
   endtask

   // Monitor: compare on every output transfer; check stall behaviour
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (!Reset) begin
            if (out_valid && !out_ready) chk("full_stall_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("R_out", int'(R_out), e.r);
                  chk("G_out", int'(G_out), e.g);
                  chk("B_out", int'(B_out), e.b);
                  chk("sof", int'(sof), int'(e.s));
                  chk("eol", int'(eol), int'(e.l));
                  chk("eof", int'(eof), int'(e.f));
                  if (lat_chk) chk("latency", cyc - e.cyc, 3);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_gains(UNITY, UNITY, UNITY, 0);
      do_reset();

      // Unity gain, no backpressure, exact latency
      lat_chk = 1;
      for (int i = 0; i < NPIX; i++) send($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 0);
      drain();
      lat_chk = 0;

      // Saturation (gain 2.0) and round-half-up (gain 0.5)
      do_reset();
      set_gains(512, 128, UNITY, 0);
      for (int i = 0; i < 20; i++)
         send((i % 2) ? 'h7F : 'h90, (i % 2) ? 'h01 : 'h81, $urandom_range(0, MAXV), 0);
      drain();

      // Backpressure with unity gain, then random gains changing every pixel
      do_reset();
      set_gains(UNITY, UNITY, UNITY, 0);
      for (int i = 0; i < NPIX; i++) send($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1);
      for (int i = 0; i < 360; i++) begin
         set_gains($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
         send($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1);
      end
      drain();

      // Mid-frame gain_B change and bypass request, effective next frame
      do_reset();
      for (int i = 0; i < 650; i++) begin
         set_gains($urandom_range(0, 1023), UNITY, (i < 150) ? UNITY : 384, (i >= 450));
         send($urandom_range(0, MAXV), $urandom_range(0, MAXV), (i % 3 == 0) ? 'h40 : $urandom_range(0, MAXV), 1);
      end
      drain();

      // Reset at pixel 77 with data in flight
      do_reset();
      set_gains(UNITY, UNITY, UNITY, 0);
      for (int i = 0; i < 77; i++) send($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1);
      set_gains(384, 700, 100, 1);
      do_reset();
      set_gains(UNITY, UNITY, UNITY, 0);
      for (int i = 0; i < 40; i++) send($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
